// File: rtl/enemy_fire_scheduler_pkg.sv
// Formation constants and scheduler state encoding, shared with the
// formation-movement and render logic.
package enemy_fire_scheduler_pkg;

    localparam int ROWS    = 5;
    localparam int COLS    = 13;
    localparam int N_ENEMY = ROWS * COLS;
    localparam int ID_W    = $clog2(N_ENEMY);
    localparam int COL_W   = $clog2(COLS);
    localparam int CNT_W   = $clog2(N_ENEMY + 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        SCAN,
        FIRE
    } state_t;

    // Round-robin column successor.
    function automatic logic [COL_W-1:0] next_col(input logic [COL_W-1:0] col);
        return (col == COL_W'(COLS - 1)) ? '0 : col + COL_W'(1);
    endfunction

endpackage

// File: rtl/enemy_fire_scheduler_if.sv
// Shot request channel from the fire scheduler to the enemy-munition block.
interface enemy_fire_scheduler_if;
    import enemy_fire_scheduler_pkg::*;

    logic             fire_valid;
    logic             fire_ready;
    logic [ID_W-1:0]  fire_id;
    logic [COL_W-1:0] fire_col;

    modport master (
        output fire_valid,
        output fire_id,
        output fire_col,
        input  fire_ready
    );

    modport slave (
        input  fire_valid,
        input  fire_id,
        input  fire_col,
        output fire_ready
    );

endinterface

// File: rtl/alive_popcount.sv
// Combinational count of set bits in the formation alive mask.
module alive_popcount #(
    parameter int N = 8
) (
    input  logic [N-1:0]             mask,
    output logic [$clog2(N+1)-1:0]   count
);

    localparam int CW = $clog2(N + 1);

    always_comb begin
        count = '0;
        for (int i = 0; i < N; i++) begin
            count = count + CW'(mask[i]);
        end
    end

endmodule

// File: rtl/enemy_fire_scheduler.sv
// Picks when the formation fires and which enemy shoots: round-robin over
// columns, bottom-most alive enemy, interval shrinking with each kill.
module enemy_fire_scheduler
    import enemy_fire_scheduler_pkg::*;
#(
    parameter int PERIOD     = 10000000,
    parameter int MIN_PERIOD = 2000000,
    parameter int STEP       = 100000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [N_ENEMY-1:0]   alive,
    enemy_fire_scheduler_if.master fire,
    output logic [15:0]          shots_fired
);

    localparam int TIMER_W = $clog2(PERIOD + 1);
    localparam int SPAN    = PERIOD - MIN_PERIOD;

    state_t             state_reg, state_next;
    logic [TIMER_W-1:0] timer_reg, timer_next;
    logic [COL_W-1:0]   col_ptr_reg, col_ptr_next;
    logic [COL_W-1:0]   scan_cnt_reg, scan_cnt_next;
    logic [ID_W-1:0]    fire_id_reg, fire_id_next;
    logic [COL_W-1:0]   fire_col_reg, fire_col_next;
    logic [15:0]        shots_reg, shots_next;

    // Firing interval from the current kill count.
    logic [CNT_W-1:0]   alive_cnt;
    int                 killed;
    int                 step_drop;
    logic [TIMER_W-1:0] cur_period;

    alive_popcount #(.N(N_ENEMY)) u_alive_popcount (
        .mask  (alive),
        .count (alive_cnt)
    );

    // The drop is compared against the span first so nothing ever underflows.
    always_comb begin
        killed    = N_ENEMY - int'(alive_cnt);
        step_drop = killed * STEP;
        if (step_drop > SPAN) begin
            cur_period = TIMER_W'(MIN_PERIOD);
        end else begin
            cur_period = TIMER_W'(PERIOD - step_drop);
        end
    end

    // Column-major view of the alive mask for the bottom-finder.
    logic [ROWS-1:0] col_bits [COLS];

    for (genvar gi = 0; gi < COLS; gi++) begin : g_col
        for (genvar gj = 0; gj < ROWS; gj++) begin : g_row
            assign col_bits[gi][gj] = alive[gj*COLS + gi];
        end
    end

    logic            found;
    logic [ID_W-1:0] found_id;

    // Later rows override earlier ones, so the highest alive row wins.
    always_comb begin
        found    = 1'b0;
        found_id = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (col_bits[col_ptr_reg][r]) begin
                found    = 1'b1;
                found_id = ID_W'(r * COLS) + ID_W'(col_ptr_reg);
            end
        end
    end

    logic handshake;
    assign handshake = (state_reg == FIRE) && fire.fire_ready;

    always_comb begin
        state_next    = state_reg;
        timer_next    = timer_reg;
        col_ptr_next  = col_ptr_reg;
        scan_cnt_next = scan_cnt_reg;
        fire_id_next  = fire_id_reg;
        fire_col_next = fire_col_reg;
        shots_next    = shots_reg;

        // A handshake already presented on the bus still counts when the game halts.
        if (handshake) begin
            col_ptr_next = next_col(fire_col_reg);
            shots_next   = (shots_reg == 16'hFFFF) ? shots_reg : shots_reg + 16'd1;
        end

        if (!enable) begin
            state_next = IDLE;
            timer_next = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    timer_next = cur_period;
                    state_next = WAIT;
                end
                WAIT: begin
                    if (timer_reg <= TIMER_W'(1)) begin
                        state_next    = SCAN;
                        scan_cnt_next = '0;
                        timer_next    = '0;
                    end else begin
                        timer_next = timer_reg - TIMER_W'(1);
                    end
                end
                SCAN: begin
                    if (found) begin
                        state_next    = FIRE;
                        fire_id_next  = found_id;
                        fire_col_next = col_ptr_reg;
                    end else begin
                        col_ptr_next  = next_col(col_ptr_reg);
                        scan_cnt_next = scan_cnt_reg + COL_W'(1);
                        if (scan_cnt_reg == COL_W'(COLS - 1)) begin
                            timer_next = cur_period;
                            state_next = WAIT;
                        end
                    end
                end
                FIRE: begin
                    if (fire.fire_ready) begin
                        timer_next = cur_period;
                        state_next = WAIT;
                    end else if (!alive[fire_id_reg]) begin
                        state_next    = SCAN;
                        scan_cnt_next = '0;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            timer_reg    <= '0;
            col_ptr_reg  <= '0;
            scan_cnt_reg <= '0;
            fire_id_reg  <= '0;
            fire_col_reg <= '0;
            shots_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            timer_reg    <= timer_next;
            col_ptr_reg  <= col_ptr_next;
            scan_cnt_reg <= scan_cnt_next;
            fire_id_reg  <= fire_id_next;
            fire_col_reg <= fire_col_next;
            shots_reg    <= shots_next;
        end
    end

    assign fire.fire_valid = (state_reg == FIRE);
    assign fire.fire_id    = fire_id_reg;
    assign fire.fire_col   = fire_col_reg;
    assign shots_fired     = shots_reg;

endmodule

// File: tb/tb_enemy_fire_scheduler.sv
// Directed scenarios plus randomized play, checked every cycle against a
// behavioural model of the scheduler's firing rules.
module tb_enemy_fire_scheduler;
    import enemy_fire_scheduler_pkg::*;

    localparam int PERIOD     = 20;
    localparam int MIN_PERIOD = 8;
    localparam int STEP       = 2;

    localparam int M_IDLE = 0;
    localparam int M_WAIT = 1;
    localparam int M_SCAN = 2;
    localparam int M_FIRE = 3;

    logic               clk = 1'b0;
    logic               reset;
    logic               enable;
    logic               fire_ready;
    logic [N_ENEMY-1:0] alive;
    logic [15:0]        shots_fired;

    always #5 clk = ~clk;

    enemy_fire_scheduler_if fire_bus ();
    assign fire_bus.fire_ready = fire_ready;

    enemy_fire_scheduler #(
        .PERIOD     (PERIOD),
        .MIN_PERIOD (MIN_PERIOD),
        .STEP       (STEP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .alive       (alive),
        .fire        (fire_bus),
        .shots_fired (shots_fired)
    );

    int checks = 0;
    int errors = 0;
    bit chk_on = 1'b0;

    // Model state
    int m_mode, m_timer, m_ptr, m_cnt, m_id, m_col, m_shots;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int bottom_row(input logic [N_ENEMY-1:0] a, input int col);
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (a[r*COLS + col]) return r;
        end
        return -1;
    endfunction

    function automatic int period_of(input logic [N_ENEMY-1:0] a);
        int p;
        p = PERIOD - (N_ENEMY - $countones(a)) * STEP;
        return (p < MIN_PERIOD) ? MIN_PERIOD : p;
    endfunction

    task automatic count_shot();
        m_shots = (m_shots < 65535) ? m_shots + 1 : 65535;
        m_ptr   = (m_col + 1) % COLS;
    endtask

    task automatic model_step();
        int r;
        if (reset) begin
            m_mode = M_IDLE; m_timer = 0; m_ptr = 0; m_cnt = 0;
            m_id = 0; m_col = 0; m_shots = 0;
        end else if (!enable) begin
            if (m_mode == M_FIRE && fire_ready) count_shot();
            m_mode = M_IDLE;
        end else begin
            case (m_mode)
                M_IDLE: begin
                    m_timer = period_of(alive);
                    m_mode  = M_WAIT;
                end
                M_WAIT: begin
                    if (m_timer == 1) begin
                        m_mode = M_SCAN;
                        m_cnt  = 0;
                    end else begin
                        m_timer--;
                    end
                end
                M_SCAN: begin
                    r = bottom_row(alive, m_ptr);
                    if (r >= 0) begin
                        m_id   = r * COLS + m_ptr;
                        m_col  = m_ptr;
                        m_mode = M_FIRE;
                    end else begin
                        m_ptr = (m_ptr + 1) % COLS;
                        m_cnt++;
                        if (m_cnt == COLS) begin
                            m_timer = period_of(alive);
                            m_mode  = M_WAIT;
                        end
                    end
                end
                default: begin
                    if (fire_ready) begin
                        count_shot();
                        m_timer = period_of(alive);
                        m_mode  = M_WAIT;
                    end else if (!alive[m_id]) begin
                        m_mode = M_SCAN;
                        m_cnt  = 0;
                    end
                end
            endcase
        end
    endtask

    // Every-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (chk_on) begin
            check("valid", int'(fire_bus.fire_valid), int'(m_mode == M_FIRE));
            check("fire_id", int'(fire_bus.fire_id), m_id);
            check("fire_col", int'(fire_bus.fire_col), m_col);
            check("shots", int'(shots_fired), m_shots);
            if (fire_bus.fire_valid && fire_ready && !reset)
                $display("shot id=%0d col=%0d count_before=%0d t=%0t",
                         fire_bus.fire_id, fire_bus.fire_col, shots_fired, $time);
        end
    end

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic wait_fire(input int max, output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!fire_bus.fire_valid && n < max);
        if (!fire_bus.fire_valid) check("fire_timeout", 0, 1);
    endtask

    int n, nv, exp_id;

    initial begin
        reset = 1'b1; enable = 1'b1; fire_ready = 1'b0; alive = '1;
        @(negedge clk);
        step(); step();
        chk_on = 1'b1;
        check("rst_valid", int'(fire_bus.fire_valid), 0);
        check("rst_shots", int'(shots_fired), 0);
        check("rst_id", int'(fire_bus.fire_id), 0);

        // First shot latency and shooter
        reset = 1'b0;
        wait_fire(40, n);
        check("first_lat", n, 22);
        check("first_id", int'(fire_bus.fire_id), 52);

        // Back-pressure: held stable, accepted when ready rises
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", int'(fire_bus.fire_valid), 1);
            check("hold_id", int'(fire_bus.fire_id), 52);
            step();
        end
        fire_ready = 1'b1;
        step();
        check("accept_valid", int'(fire_bus.fire_valid), 0);
        check("accept_shots", int'(shots_fired), 1);

        // Round-robin across a full formation
        for (int i = 1; i <= 13; i++) begin
            wait_fire(40, n);
            exp_id = 52 + (i % 13);
            check("rr_gap", n, (i == 1) ? 21 : 22);
            check("rr_id", int'(fire_bus.fire_id), exp_id);
            check("rr_shots", int'(shots_fired), i);
        end

        // Two kills in column 0: period 16, column 0 shooter moves up
        alive[52] = 1'b0;
        alive[39] = 1'b0;
        for (int i = 1; i <= 13; i++) begin
            wait_fire(40, n);
            if (i == 1) begin
                check("k2_gap", n, 18);
                check("k2_id", int'(fire_bus.fire_id), 53);
            end
            if (i == 13) begin
                check("col0_id", int'(fire_bus.fire_id), 26);
                check("col0_col", int'(fire_bus.fire_col), 0);
            end
        end

        // Ten kills: interval clamps to the floor
        alive[7:0] = '0;
        wait_fire(40, n);
        check("clamp_gap", n, 10);
        check("clamp_id", int'(fire_bus.fire_id), 53);

        // Shooter dies while waiting for ready
        fire_ready = 1'b0; alive = '1; reset = 1'b1;
        step(); step();
        reset = 1'b0;
        wait_fire(40, n);
        check("re_first_id", int'(fire_bus.fire_id), 52);
        alive[52] = 1'b0;
        step();
        check("drop_valid", int'(fire_bus.fire_valid), 0);
        wait_fire(5, n);
        check("rescan_lat", n, 1);
        check("rescan_id", int'(fire_bus.fire_id), 39);

        // Handshake and death together: shot counts, pointer advances
        fire_ready = 1'b1;
        alive[39] = 1'b0;
        step();
        check("tie_valid", int'(fire_bus.fire_valid), 0);
        check("tie_shots", int'(shots_fired), 1);
        wait_fire(40, n);
        check("tie_next_id", int'(fire_bus.fire_id), 53);
        check("tie_next_col", int'(fire_bus.fire_col), 1);

        // Empty formation never fires
        alive = '0;
        nv = 0;
        for (int i = 0; i < 60; i++) begin
            step();
            if (fire_bus.fire_valid) nv++;
        end
        check("empty_no_fire", nv, 0);

        // Halt mid-wait, then resume with a full reload
        for (int k = 0; k < 50 && !(m_mode == M_WAIT && m_timer > 3); k++) step();
        enable = 1'b0;
        step();
        check("halt_valid", int'(fire_bus.fire_valid), 0);
        alive = '1;
        step(); step(); step();
        enable = 1'b1;
        wait_fire(40, n);
        check("reen_lat", n, 22);
        check("reen_id", int'(fire_bus.fire_id), 54);

        // Randomized play
        for (int cyc = 0; cyc < 4000; cyc++) begin
            fire_ready = ($urandom_range(0, 2) != 0);
            enable     = ($urandom_range(0, 99) != 0);
            reset      = ($urandom_range(0, 999) == 0);
            if ($urandom_range(0, 3) == 0) begin
                int idx;
                idx = $urandom_range(0, N_ENEMY - 1);
                alive[idx] = ~alive[idx];
            end
            if ($urandom_range(0, 199) == 0) alive = '1;
            if ($urandom_range(0, 299) == 0) begin
                logic [95:0] rnd;
                rnd = {$urandom, $urandom, $urandom};
                alive = rnd[N_ENEMY-1:0];
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/enemy_fire_scheduler.md
Name: enemy_fire_scheduler

Overview:
- Decides when the enemy formation fires and which alive enemy fires.
- Sits between the formation alive mask (one bit per enemy, row-major, index = row*COLS+col) and the enemy-munition block.
- Round-robins over columns. The shooter is always the bottom-most alive enemy of the chosen column.
- The firing interval shrinks as enemies die, so the game speeds up as the player makes progress.

Parameters:
ROWS, 5, formation rows
COLS, 13, formation columns
PERIOD, 10000000, clk cycles between shots with full formation
MIN_PERIOD, 2000000, floor on the interval
STEP, 100000, interval reduction per dead enemy
ID_W, $clog2(ROWS*COLS) = 7, width of enemy index

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
enable  in  1  game-running flag; 0 halts scheduling
alive  in  ROWS*COLS  alive mask, bit i = enemy i
fire_ready  in  1  munition idle, can accept a shot
fire_valid  out  1  shot request
fire_id  out  ID_W  index of shooting enemy, stable while fire_valid=1
fire_col  out  $clog2(COLS)  column of fire_id
shots_fired  out  16  saturating count of accepted shots (debug/HEX)

Behaviour:
- Clock and reset: one clock (clk). reset is synchronous and active-high.
- Reset values:
  - state=IDLE, timer=0, col_ptr=0.
  - fire_valid=0, fire_id=0, fire_col=0, shots_fired=0.
  - Reset has priority over all else, including an in-flight handshake.
- States: IDLE, WAIT, SCAN, FIRE.
- IDLE:
  - Outputs are held; fire_valid=0.
  - When enable=1: load timer with cur_period and go to WAIT.
- cur_period:
  - killed = ROWS*COLS - popcount(alive).
  - cur_period = PERIOD - killed*STEP if that result is >= MIN_PERIOD, else MIN_PERIOD.
  - Computed without unsigned underflow: compare killed*STEP against PERIOD-MIN_PERIOD first.
  - Sampled only at the moment the timer is loaded.
- WAIT:
  - timer decrements by 1 each cycle.
  - When timer==1 (i.e. the cur_period-th cycle since load), go to SCAN next cycle with scan_cnt=0.
- SCAN (one column per cycle):
  - Examine column col_ptr. Bottom-most alive = the highest r in 0..ROWS-1 with alive[r*COLS+col_ptr]=1.
  - Found:
    - Next cycle state=FIRE, fire_valid=1.
    - fire_id = r*COLS+col_ptr, fire_col = col_ptr.
  - Not found:
    - col_ptr = (col_ptr+1) mod COLS; scan_cnt++.
    - If scan_cnt reaches COLS (empty formation): reload timer, go to WAIT, no shot.
- FIRE:
  - fire_valid=1 and fire_id held until the handshake fire_valid & fire_ready completes.
  - On handshake:
    - Next cycle fire_valid=0.
    - col_ptr = (fire_col+1) mod COLS.
    - shots_fired += 1, saturating at 0xFFFF.
    - Timer loaded with cur_period; state=WAIT.
  - If alive[fire_id] falls to 0 while in FIRE and there is no handshake that cycle:
    - Next cycle fire_valid=0; return to SCAN with col_ptr unchanged and scan_cnt=0.
    - The next-higher alive enemy of that column becomes the candidate.
  - If the handshake and the alive drop happen in the same cycle, the handshake wins and the shot counts.
- enable=0 in any state:
  - Next cycle state=IDLE, fire_valid=0.
  - The timer is discarded; col_ptr and shots_fired are kept.
- Latency:
  - Timer load to fire_valid = cur_period + 1 + k cycles, where k = number of empty columns skipped before the shooter column.
  - Minimum from SCAN entry to fire_valid = 1 cycle.
- fire_ready is ignored outside FIRE.

Decomposition:
- Shared package (the formation constants are also used by the formation-movement and render logic):
  - Constants ROWS, COLS, ID_W.
  - Enumerated state encoding {IDLE, WAIT, SCAN, FIRE}.
- One sub-module: alive_popcount (parameter N, input N-bit mask, output $clog2(N+1)-bit count, purely combinational). It feeds cur_period.
- The column bottom-finder stays inline as a per-column priority loop.

Test Plan:
- Bench parameters for all scenarios: PERIOD=20, MIN_PERIOD=8, STEP=2.
1. reset=1 for 2 cycles with enable=1 -> fire_valid=0, shots_fired=0, state IDLE. Release reset -> first fire_valid exactly 1(IDLE) + 20(WAIT) + 1(SCAN) cycles later, with fire_id=52 (row 4, col 0).
2. Full mask, fire_ready tied 1 -> successive fire_id 52, 53, 54 … 64, 52 (round-robin wrap). Shots spaced 22 cycles. shots_fired increments per shot.
3. Clear alive bits 52 and 39 (column 0, rows 4 and 3) -> column 0 shot uses fire_id=26. killed=2 gives period 16; killed=10 gives 0 → clamped to 8.
4. fire_ready=0 held 5 cycles in FIRE -> fire_valid and fire_id stable for all 5 cycles; the shot is accepted on the cycle fire_ready rises.
5. In FIRE with fire_id=52, drop alive[52] with fire_ready=0 -> fire_valid falls, a re-scan occurs, next fire_id=39. Dropping alive[52] in the same cycle as the handshake -> shot counted, col_ptr=1.
6. alive=0 -> SCAN walks 13 columns, no fire_valid, returns to WAIT. Drop enable mid-WAIT -> IDLE next cycle. Re-enable -> full period reloaded.
